mxu_result_drain: RTL and testbench



---
 rtl/mxu_result_drain.sv | 166 ++++++++++++++++
 tb/tb_mxu_result_drain.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mxu_result_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mxu_result_drain
// Description : Captures the MXU result matrix and requantizes it (rounding
//               shift plus saturation). It then streams one row per beat on a
//               valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module mxu_result_drain #(
    parameter int DIM       = 16,
    parameter int BIT_WIDTH = 8,
    parameter int OUT_W     = 2 * BIT_WIDTH,
    parameter int SHIFT_W   = 4,
    parameter int IDX_W     = (DIM > 1) ? $clog2(DIM) : 1,
    parameter int SAT_W     = $clog2(DIM * DIM + 1)
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [DIM*DIM*OUT_W-1:0]   in_data,
    input  logic [SHIFT_W-1:0]         shift,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIM*BIT_WIDTH-1:0]   out_row,
    output logic [IDX_W-1:0]           out_row_idx,
    output logic                       out_last,
    output logic                       done,
    output logic                       busy,
    output logic [SAT_W-1:0]           sat_count,
    output logic                       drop_err
);

    localparam int                       C_ROW_W     = DIM * OUT_W;
    localparam logic signed [OUT_W:0]    C_QMAX      = (OUT_W+1)'((1 << (BIT_WIDTH - 1)) - 1);
    localparam logic signed [OUT_W:0]    C_QMIN      = ~C_QMAX;
    localparam logic [SHIFT_W-1:0]       C_SHIFT_MAX = SHIFT_W'(OUT_W - 1);
    localparam logic [IDX_W-1:0]         C_LAST_IDX  = IDX_W'(DIM - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t                      r_state;
    logic                        r_in_valid_q;
    logic [DIM*DIM*OUT_W-1:0]    r_cap;
    logic [SHIFT_W-1:0]          r_shift;

    logic                        w_rise;
    logic                        w_accept;
    logic [IDX_W-1:0]            w_req_idx;
    logic [C_ROW_W-1:0]          w_cap_rows [DIM];
    logic [C_ROW_W-1:0]          w_sel_row;
    logic signed [OUT_W:0]       w_rnd;
    logic [DIM*BIT_WIDTH-1:0]    w_q_row;
    logic [DIM-1:0]              w_sat_vec;
    logic [SAT_W-1:0]            w_row_sat;

    assign w_rise   = in_valid & ~r_in_valid_q;
    assign w_accept = out_valid & out_ready;

    // Row to load next: row 0 while preparing, otherwise the one after the row on the bus.
    assign w_req_idx = (r_state == S_SEND) ? out_row_idx + IDX_W'(1) : '0;

    generate
        for (genvar m = 0; m < DIM; m++) begin : g_row
            assign w_cap_rows[m] = r_cap[m*C_ROW_W +: C_ROW_W];
        end
    endgenerate

    assign w_sel_row = w_cap_rows[w_req_idx];
    assign w_rnd     = (r_shift == '0) ? '0 : ((OUT_W+1)'(1) << (r_shift - SHIFT_W'(1)));

    generate
        for (genvar n = 0; n < DIM; n++) begin : g_col
            logic signed [OUT_W-1:0] w_x;
            logic signed [OUT_W:0]   w_t;
            logic signed [OUT_W:0]   w_y;
            logic                    w_hi;
            logic                    w_lo;

            assign w_x  = w_sel_row[n*OUT_W +: OUT_W];
            // One extra bit so the rounding offset cannot overflow the sum.
            assign w_t  = {w_x[OUT_W-1], w_x} + w_rnd;
            assign w_y  = w_t >>> r_shift;
            assign w_hi = (w_y > C_QMAX);
            assign w_lo = (w_y < C_QMIN);
            assign w_sat_vec[n] = w_hi | w_lo;
            assign w_q_row[n*BIT_WIDTH +: BIT_WIDTH] =
                w_hi ? C_QMAX[BIT_WIDTH-1:0] :
                w_lo ? C_QMIN[BIT_WIDTH-1:0] : w_y[BIT_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        w_row_sat = '0;
        for (int n = 0; n < DIM; n++) begin
            w_row_sat = w_row_sat + SAT_W'(w_sat_vec[n]);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state      <= S_IDLE;
            r_in_valid_q <= 1'b0;
            r_cap        <= '0;
            r_shift      <= '0;
            out_valid    <= 1'b0;
            out_row      <= '0;
            out_row_idx  <= '0;
            out_last     <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            sat_count    <= '0;
            drop_err     <= 1'b0;
        end else begin
            r_in_valid_q <= in_valid;
            done         <= 1'b0;

            if (w_rise && (r_state != S_IDLE)) begin
                drop_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_cap       <= in_data;
                        r_shift     <= (shift > C_SHIFT_MAX) ? C_SHIFT_MAX : shift;
                        sat_count   <= '0;
                        out_row_idx <= '0;
                        busy        <= 1'b1;
                        r_state     <= S_PREP;
                    end
                end
                S_PREP: begin
                    out_row     <= w_q_row;
                    out_row_idx <= w_req_idx;
                    out_last    <= (w_req_idx == C_LAST_IDX);
                    sat_count   <= sat_count + w_row_sat;
                    out_valid   <= 1'b1;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (w_accept) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            out_row     <= w_q_row;
                            out_row_idx <= w_req_idx;
                            out_last    <= (w_req_idx == C_LAST_IDX);
                            sat_count   <= sat_count + w_row_sat;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mxu_result_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mxu_result_drain
// Description : Scoreboard bench for mxu_result_drain with a 4x4 matrix.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mxu_result_drain;

    localparam int DIM  = 4;
    localparam int BW   = 8;
    localparam int OW   = 16;
    localparam int SW   = 4;
    localparam int IW   = 2;
    localparam int SATW = 5;

    typedef struct packed {
        logic [DIM*BW-1:0] row;
        logic [IW-1:0]     idx;
        logic              last;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    clear;
    logic                    in_valid;
    logic [DIM*DIM*OW-1:0]   in_data;
    logic [SW-1:0]           shift;
    logic                    out_valid;
    logic                    out_ready;
    logic [DIM*BW-1:0]       out_row;
    logic [IW-1:0]           out_row_idx;
    logic                    out_last;
    logic                    done;
    logic                    busy;
    logic [SATW-1:0]         sat_count;
    logic                    drop_err;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_beats  = 0;
    bit    done_due = 1'b0;
    beat_t q[$];
    beat_t mon_act;
    beat_t mon_exp;

    always #5 clk = ~clk;

    mxu_result_drain #(
        .DIM(DIM), .BIT_WIDTH(BW), .OUT_W(OW), .SHIFT_W(SW), .IDX_W(IW), .SAT_W(SATW)
    ) dut (
        .clk(clk), .clear(clear), .in_valid(in_valid), .in_data(in_data), .shift(shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_row_idx(out_row_idx), .out_last(out_last), .done(done), .busy(busy),
        .sat_count(sat_count), .drop_err(drop_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DIM*BW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic set_elem(input int m, input int n, input int v);
        in_data[((m*DIM+n)*OW) +: OW] = 16'(v);
    endtask

    task automatic load_seq(input int base);
        for (int m = 0; m < DIM; m++)
            for (int n = 0; n < DIM; n++) set_elem(m, n, base + 4*m + n);
    endtask

    task automatic push_row(input logic [DIM*BW-1:0] r, input int m);
        beat_t b;
        b.row = r; b.idx = IW'(m); b.last = (m == DIM-1);
        q.push_back(b);
    endtask

    task automatic push_seq(input int base, input int first_m);
        for (int m = first_m; m < DIM; m++)
            push_row(pack4(base+4*m, base+4*m+1, base+4*m+2, base+4*m+3), m);
    endtask

    task automatic rise();
        @(posedge clk); #1 in_valid = 1'b1;
    endtask

    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
        chk({name, "_done_seen"}, 64'(got), 64'd1);
    endtask

    task automatic wait_beat(input int idx, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid && out_row_idx == IW'(idx)) begin got = 1'b1; break; end
        end
        chk({name, "_beat_seen"}, 64'(got), 64'd1);
    endtask

    // Monitor: compares every presented beat with the head of the queue, pops on handshake.
    always @(negedge clk) begin
        if (done || done_due) chk("done_pulse", 64'(done), 64'(done_due));
        done_due = 1'b0;
        if (out_valid) begin
            mon_act.row = out_row; mon_act.idx = out_row_idx; mon_act.last = out_last;
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL beat_unexpected: got row 0x%0h idx %0d expected no beat", out_row, out_row_idx);
            end else begin
                mon_exp = q[0];
                chk("beat", 64'(mon_act), 64'(mon_exp));
                if (out_ready) begin
                    void'(q.pop_front());
                    n_beats++;
                    if (mon_exp.last) done_due = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int beats0;
        clear = 1'b1; in_valid = 1'b0; in_data = '0; shift = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 64'({out_valid, busy, done, drop_err, out_last, out_row_idx, sat_count, out_row}), 64'd0);
        @(posedge clk); #1 clear = 1'b0;

        // Test 1: plain drain, level held high must not re-capture
        load_seq(0); shift = 4'd0; push_seq(0, 0);
        @(posedge clk); #1 in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); chk("t1_prep_busy_novalid", 64'({busy, out_valid}), 64'b10);
        @(negedge clk); chk("t1_valid_2nd_clock", 64'(out_valid), 64'd1);
        wait_done("t1");
        chk("t1_sat", 64'(sat_count), 64'd0);
        chk("t1_busy_after", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); chk("t1_no_recapture", 64'({drop_err, busy}), 64'd0);
        @(posedge clk); #1 in_valid = 1'b0;

        // Test 2: saturation
        in_data = '0;
        set_elem(0, 0, 300); set_elem(0, 1, -300); set_elem(0, 2, 127); set_elem(0, 3, -128);
        push_row(pack4(127, -128, 127, -128), 0);
        for (int m = 1; m < DIM; m++) push_row('0, m);
        rise(); @(posedge clk); #1 in_valid = 1'b0;
        wait_done("t2");
        chk("t2_sat", 64'(sat_count), 64'd2);

        // Test 3a: rounding shift of 2
        @(posedge clk); #1 in_data = '0; shift = 4'd2;
        set_elem(0, 0, 5); set_elem(0, 1, 6); set_elem(0, 2, -6); set_elem(0, 3, -7);
        set_elem(1, 0, 2); set_elem(1, 1, -2); set_elem(1, 2, 1); set_elem(1, 3, -1);
        push_row(pack4(1, 2, -1, -2), 0); push_row(pack4(1, 0, 0, 0), 1);
        push_row('0, 2); push_row('0, 3);
        rise(); @(posedge clk); #1 in_valid = 1'b0;
        wait_done("t3a");
        chk("t3a_sat", 64'(sat_count), 64'd0);

        // Test 3b: maximum shift
        @(posedge clk); #1 in_data = '0; shift = 4'hF;
        set_elem(0, 0, 16'h4000); set_elem(0, 1, 16'h3FFF); set_elem(0, 2, -16384); set_elem(0, 3, -32768);
        push_row(pack4(1, 0, 0, -1), 0);
        for (int m = 1; m < DIM; m++) push_row('0, m);
        rise(); @(posedge clk); #1 in_valid = 1'b0;
        wait_done("t3b");

        // Test 4: backpressure on the idx 1 beat
        @(posedge clk); #1 shift = 4'd0; load_seq(16); push_seq(16, 0);
        beats0 = n_beats;
        rise();
        wait_beat(0, "t4");
        @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done("t4");
        chk("t4_beat_count", 64'(n_beats - beats0), 64'd4);
        chk("t4_drop_err", 64'(drop_err), 64'd0);

        // Test 5: overrun during row 2, then a clean capture of the new data
        @(posedge clk); #1 load_seq(40); push_seq(40, 0);
        rise(); @(posedge clk); #1 in_valid = 1'b0;
        wait_beat(1, "t5");
        @(posedge clk); #1 out_ready = 1'b0; load_seq(100); in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done("t5a");
        chk("t5_drop_err_set", 64'(drop_err), 64'd1);
        @(posedge clk); #1 in_valid = 1'b0; push_seq(100, 0);
        rise(); @(posedge clk); #1 in_valid = 1'b0;
        wait_done("t5b");
        chk("t5_drop_err_sticky", 64'(drop_err), 64'd1);

        // Test 6: clear while idx 2 is on the bus
        @(posedge clk); #1 load_seq(60); set_elem(0, 0, 1000);
        push_row(pack4(127, 61, 62, 63), 0); push_seq(60, 1);
        rise(); @(posedge clk); #1 in_valid = 1'b0;
        wait_beat(1, "t6");
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        chk("t6_pre_clear", 64'({out_row_idx, sat_count, drop_err}), 64'({2'd2, 5'd1, 1'b1}));
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0; q.delete(); out_ready = 1'b1;
        @(negedge clk);
        chk("t6_post_clear", 64'({out_valid, busy, out_row_idx, sat_count, drop_err, done}), 64'd0);
        load_seq(80); push_seq(80, 0);
        rise(); @(posedge clk); #1 in_valid = 1'b0;
        wait_done("t6");
        chk("t6_final", 64'({drop_err, sat_count, busy}), 64'd0);
        chk("queue_empty", 64'(q.size()), 64'd0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
